// File: rtl/stopwatch_display_driver.sv
// rtl/stopwatch_display_driver.sv - stopwatch MM.SS binary-to-BCD converter and 4-digit seven-segment scanner
module stopwatch_display_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       sample,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy,
  output logic       range_err
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      m_sh, s_sh, m_bcd, s_bcd;
  logic [15:0]     m_next, s_next;
  logic [2:0]      iter;
  logic            err_pend;
  logic [3:0][3:0] digits;
  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic [3:0]      cur;
  logic [6:0]      seg_nxt;

  function automatic logic [7:0] dabble_adj(input logic [7:0] b);
    logic [3:0] hi, lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = CONV;
      CONV:    if (iter == 3'd7) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    m_next = {dabble_adj(m_bcd), m_sh} << 1;
    s_next = {dabble_adj(s_bcd), s_sh} << 1;
  end

  // Digits are only written in COMMIT, so the display never sees a half-converted value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh      <= '0;
      s_sh      <= '0;
      m_bcd     <= '0;
      s_bcd     <= '0;
      iter      <= '0;
      err_pend  <= 1'b0;
      digits    <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sample) begin
          m_sh     <= clamp99(minutes);
          s_sh     <= clamp99(seconds);
          m_bcd    <= '0;
          s_bcd    <= '0;
          iter     <= '0;
          err_pend <= (minutes > 8'd99) || (seconds > 8'd99);
        end
        CONV: begin
          m_bcd <= m_next[15:8];
          m_sh  <= m_next[7:0];
          s_bcd <= s_next[15:8];
          s_sh  <= s_next[7:0];
          iter  <= iter + 3'd1;
        end
        COMMIT: begin
          digits    <= {m_bcd, s_bcd};
          range_err <= err_pend;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    cur = digits[idx];
    case (cur)
      4'd0:    seg_nxt = 7'b0111111;
      4'd1:    seg_nxt = 7'b0000110;
      4'd2:    seg_nxt = 7'b1011011;
      4'd3:    seg_nxt = 7'b1001111;
      4'd4:    seg_nxt = 7'b1100110;
      4'd5:    seg_nxt = 7'b1101101;
      4'd6:    seg_nxt = 7'b1111101;
      4'd7:    seg_nxt = 7'b0000111;
      4'd8:    seg_nxt = 7'b1111111;
      4'd9:    seg_nxt = 7'b1101111;
      default: seg_nxt = 7'b0000000;
    endcase
    if (LZ_BLANK && idx == 2'd3 && cur == 4'd0) seg_nxt = 7'b0000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'b0111111;
      dp  <= 1'b0;
      an  <= 4'b0001;
    end else begin
      seg <= seg_nxt;
      dp  <= (idx == 2'd2);
      an  <= 4'b0001 << idx;
    end
  end

endmodule
